// File: rtl/regpair_seq.sv
// Register-pair increment/decrement sequencer: reads a low/high register pair through
// a single read port, adds or subtracts one, and writes both halves back.
module regpair_seq #(
    parameter int DATASIZE = 8,
    parameter int REGBIT   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    opdec,
    input  logic [1:0]              pair,
    output logic                    r1enb,
    output logic [REGBIT-1:0]       r1add,
    input  logic [DATASIZE-1:0]     r1dat,
    output logic                    wrenb,
    output logic [REGBIT-1:0]       waddr,
    output logic [DATASIZE-1:0]     wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2*DATASIZE-1:0]   result,
    output logic                    rzero
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on accept
    // RDLO  | read low register, latch low byte
    // RDHI  | read high register, form pair value +/- 1
    // WRLO  | write low half of new value
    // WRHI  | write high half of new value
    // DONE  | one-cycle completion pulse, err flags invalid pair

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDLO = 3'd1,
        RDHI = 3'd2,
        WRLO = 3'd3,
        WRHI = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int PW = 2 * DATASIZE;
    localparam logic [PW-1:0] ONE = PW'(1);

    state_t                 state, state_nxt;
    logic                   opdec_q;
    logic [1:0]             pair_q;
    logic                   err_q;
    logic [DATASIZE-1:0]    lo_q;
    logic [PW-1:0]          val_q;
    logic [PW-1:0]          result_q;
    logic                   rzero_q;

    logic [REGBIT-1:0]      lo_addr;
    logic [REGBIT-1:0]      hi_addr;
    logic [PW-1:0]          rd_val;
    logic [PW-1:0]          new_val;

    assign lo_addr = REGBIT'({pair_q, 1'b1});
    assign hi_addr = REGBIT'({pair_q, 1'b0});
    assign rd_val  = {r1dat, lo_q};
    assign new_val = opdec_q ? (rd_val - ONE) : (rd_val + ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            opdec_q  <= 1'b0;
            pair_q   <= 2'b00;
            err_q    <= 1'b0;
            lo_q     <= '0;
            val_q    <= '0;
            result_q <= '0;
            rzero_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        opdec_q <= opdec;
                        pair_q  <= pair;
                        err_q   <= (pair == 2'b11);
                    end
                end
                RDLO: lo_q  <= r1dat;
                RDHI: val_q <= new_val;
                WRHI: begin
                    // result becomes visible in the same cycle as done
                    result_q <= val_q;
                    rzero_q  <= (val_q == '0);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        r1enb     = 1'b0;
        r1add     = '0;
        wrenb     = 1'b0;
        waddr     = '0;
        wdata     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (pair == 2'b11) ? DONE : RDLO;
                end
            end
            RDLO: begin
                r1enb     = 1'b1;
                r1add     = lo_addr;
                state_nxt = RDHI;
            end
            RDHI: begin
                r1enb     = 1'b1;
                r1add     = hi_addr;
                state_nxt = WRLO;
            end
            WRLO: begin
                wrenb     = 1'b1;
                waddr     = lo_addr;
                wdata     = val_q[DATASIZE-1:0];
                state_nxt = WRHI;
            end
            WRHI: begin
                wrenb     = 1'b1;
                waddr     = hi_addr;
                wdata     = val_q[PW-1:DATASIZE];
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign err    = done & err_q;
    assign result = result_q;
    assign rzero  = rzero_q;

endmodule

// File: tb/tb_regpair_seq.sv
// Bench for regpair_seq: array register file, table vectors, corner sequences
// and randomized operations checked against a pair-arithmetic model.
module tb_regpair_seq;

    localparam int DW = 8;
    localparam int AW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           opdec = 1'b0;
    logic [1:0]     pair = 2'b00;
    logic           r1enb;
    logic [AW-1:0]  r1add;
    logic [DW-1:0]  r1dat;
    logic           wrenb;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic           busy;
    logic           done;
    logic           err;
    logic [2*DW-1:0] result;
    logic           rzero;

    regpair_seq #(.DATASIZE(DW), .REGBIT(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .opdec(opdec), .pair(pair),
        .r1enb(r1enb), .r1add(r1add), .r1dat(r1dat),
        .wrenb(wrenb), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .result(result), .rzero(rzero)
    );

    always #5 clk = ~clk;

    // register file: DUT write port has priority over the bench preload port
    logic [DW-1:0]  rf [8];
    logic           tb_we = 1'b0;
    logic [AW-1:0]  tb_wa = '0;
    logic [DW-1:0]  tb_wd = '0;

    always @(posedge clk) begin
        if (wrenb) rf[waddr] <= wdata;
        else if (tb_we) rf[tb_wa] <= tb_wd;
    end
    assign r1dat = r1enb ? rf[r1add] : '0;

    int n_rd = 0, n_wr = 0, n_both = 0, n_done = 0;
    always @(negedge clk) begin
        if (r1enb) n_rd++;
        if (wrenb) n_wr++;
        if (r1enb && wrenb) n_both++;
        if (done) n_done++;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    // reference model: pair arithmetic on a plain array
    logic [DW-1:0]   mrf [8];
    logic [2*DW-1:0] m_res = '0;
    logic            m_rz = 1'b0;

    task automatic model_op(input logic od, input logic [1:0] pr, output logic merr);
        int hi_i, lo_i;
        int v;
        hi_i = pr * 2;
        lo_i = pr * 2 + 1;
        merr = (pr == 2'b11);
        if (!merr) begin
            v = mrf[hi_i] * 256 + mrf[lo_i];
            v = od ? (v + 65535) % 65536 : (v + 1) % 65536;
            mrf[hi_i] = DW'(v / 256);
            mrf[lo_i] = DW'(v % 256);
            m_res = 16'(v);
            m_rz  = (v == 0);
        end
    endtask

    task automatic load(input logic [1:0] pr, input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = {pr, 1'b0}; tb_wd = hi;
        @(negedge clk);
        tb_wa = {pr, 1'b1}; tb_wd = lo;
        @(negedge clk);
        tb_we = 1'b0;
        mrf[{pr, 1'b0}] = hi;
        mrf[{pr, 1'b1}] = lo;
    endtask

    task automatic run_op(input logic od, input logic [1:0] pr,
                          output logic [2*DW-1:0] res, output logic rz, output logic er,
                          output int lat, output int nrd, output int nwr, output logic idle_after);
        int rd0, wr0;
        rd0 = n_rd;
        wr0 = n_wr;
        @(negedge clk);
        start = 1'b1; opdec = od; pair = pr;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = result; rz = rzero; er = err;
        @(negedge clk);
        idle_after = !busy && !done;
        nrd = n_rd - rd0;
        nwr = n_wr - wr0;
    endtask

    function automatic logic [63:0] pack_dut();
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = rf[i];
        return p;
    endfunction

    function automatic logic [63:0] pack_model();
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = mrf[i];
        return p;
    endfunction

    typedef struct {
        logic           od;
        logic [1:0]     pr;
        logic [DW-1:0]  hi;
        logic [DW-1:0]  lo;
        logic [15:0]    exp_res;
        logic           exp_rz;
        logic           exp_err;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic [2*DW-1:0] res;
        logic rz, er, merr, idle_after;
        logic [15:0] exp_pair;
        int lat, nrd, nwr, d0;
        logic od;
        logic [1:0] pr;

        vt[0] = '{1'b0, 2'b00, 8'h12, 8'hFF, 16'h1300, 1'b0, 1'b0};
        vt[1] = '{1'b0, 2'b10, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{1'b1, 2'b01, 8'h00, 8'h00, 16'hFFFF, 1'b0, 1'b0};
        vt[3] = '{1'b1, 2'b00, 8'h01, 8'h00, 16'h00FF, 1'b0, 1'b0};
        vt[4] = '{1'b1, 2'b10, 8'h00, 8'h01, 16'h0000, 1'b1, 1'b0};
        vt[5] = '{1'b0, 2'b01, 8'h7F, 8'hFF, 16'h8000, 1'b0, 1'b0};
        vt[6] = '{1'b0, 2'b11, 8'hA5, 8'h5A, 16'h8000, 1'b0, 1'b1};

        #1;
        chk("reset_outputs", 64'({busy, done, err, r1enb, wrenb, r1add, waddr, wdata, result, rzero}), 64'd0);

        for (int p = 0; p < 4; p++) load(2'(p), DW'($urandom), DW'($urandom));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            load(vt[i].pr, vt[i].hi, vt[i].lo);
            run_op(vt[i].od, vt[i].pr, res, rz, er, lat, nrd, nwr, idle_after);
            model_op(vt[i].od, vt[i].pr, merr);
            exp_pair = vt[i].exp_err ? {vt[i].hi, vt[i].lo} : vt[i].exp_res;
            chk($sformatf("vec%0d_result", i), 64'(res), 64'(vt[i].exp_res));
            chk($sformatf("vec%0d_rzero", i), 64'(rz), 64'(vt[i].exp_rz));
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 64'(lat), vt[i].exp_err ? 64'd0 : 64'd4);
            chk($sformatf("vec%0d_reads", i), 64'(nrd), vt[i].exp_err ? 64'd0 : 64'd2);
            chk($sformatf("vec%0d_writes", i), 64'(nwr), vt[i].exp_err ? 64'd0 : 64'd2);
            chk($sformatf("vec%0d_pair_regs", i), 64'({rf[{vt[i].pr, 1'b0}], rf[{vt[i].pr, 1'b1}]}), 64'(exp_pair));
            chk($sformatf("vec%0d_idle_after", i), 64'(idle_after), 64'd1);
        end
        chk("table_regfile", pack_dut(), pack_model());

        // second start while busy must be dropped
        load(2'b00, 8'h12, 8'h34);
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; opdec = 1'b0; pair = 2'b00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; opdec = 1'b1; pair = 2'b10;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        model_op(1'b0, 2'b00, merr);
        chk("busy_start_done_pulses", 64'(n_done - d0), 64'd1);
        chk("busy_start_result", 64'(result), 64'h1235);
        chk("busy_start_regfile", pack_dut(), pack_model());

        // reset asserted while the high byte is being written
        load(2'b10, 8'h00, 8'hFF);
        @(negedge clk);
        start = 1'b1; opdec = 1'b0; pair = 2'b10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrhi_outputs", 64'({wrenb, waddr, wdata}), 64'({1'b1, 3'd4, 8'h01}));
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({busy, done, err, r1enb, wrenb, r1add, waddr, wdata, result, rzero}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mrf[5] = 8'h00;
        m_res = '0;
        m_rz = 1'b0;
        chk("partial_l", 64'(rf[5]), 64'h00);
        chk("partial_h", 64'(rf[4]), 64'h00);
        run_op(1'b0, 2'b10, res, rz, er, lat, nrd, nwr, idle_after);
        model_op(1'b0, 2'b10, merr);
        chk("post_reset_latency", 64'(lat), 64'd4);
        chk("post_reset_result", 64'(res), 64'(m_res));
        chk("post_reset_result_abs", 64'(res), 64'h0001);

        // randomized operations against the model
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: load(2'($urandom_range(0, 2)), 8'hFF, 8'hFF);
                    1: load(2'($urandom_range(0, 2)), 8'h00, 8'h00);
                    default: load(2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom));
                endcase
            end
            od = 1'($urandom_range(0, 1));
            pr = 2'($urandom_range(0, 3));
            run_op(od, pr, res, rz, er, lat, nrd, nwr, idle_after);
            model_op(od, pr, merr);
            chk($sformatf("rand%0d_result", k), 64'(res), 64'(m_res));
            chk($sformatf("rand%0d_rzero", k), 64'(rz), 64'(m_rz));
            chk($sformatf("rand%0d_err", k), 64'(er), 64'(merr));
            chk($sformatf("rand%0d_latency", k), 64'(lat), merr ? 64'd0 : 64'd4);
            chk($sformatf("rand%0d_regfile", k), pack_dut(), pack_model());
        end

        chk("rd_wr_overlap", 64'(n_both), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
